// File: rtl/linebuffer_taps.sv
// Multi-tap line buffer: presents each accepted pixel together with the pixels
// at the same column in the previous NUM_TAPS_P-1 lines, behind a valid/ready register.
module linebuffer_taps #(
   parameter int unsigned WIDTH_P    = 8,
   parameter int unsigned NUM_TAPS_P = 3,
   parameter int unsigned MAX_LINE_P = 640,
   parameter int unsigned LW_P       = $clog2(MAX_LINE_P + 1),
   parameter int unsigned CW_P       = $clog2(MAX_LINE_P)
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          flush_i,
   input  logic [LW_P-1:0]               line_len_i,
   input  logic                          valid_i,
   output logic                          ready_o,
   input  logic [WIDTH_P-1:0]            data_i,
   output logic                          valid_o,
   input  logic                          ready_i,
   output logic [NUM_TAPS_P*WIDTH_P-1:0] data_o,
   output logic [NUM_TAPS_P-1:0]         tap_valid_o,
   output logic [CW_P-1:0]               col_o,
   output logic                          eol_o
);

   localparam int unsigned NL  = NUM_TAPS_P - 1;
   localparam int unsigned LCW = $clog2(NUM_TAPS_P);
   localparam logic [LCW-1:0] LC_MAX = LCW'(NUM_TAPS_P - 1);

   if (NUM_TAPS_P < 2) begin : g_bad_taps
      $fatal(1, "linebuffer_taps: NUM_TAPS_P must be at least 2");
   end
   if (MAX_LINE_P < 2) begin : g_bad_line
      $fatal(1, "linebuffer_taps: MAX_LINE_P must be at least 2");
   end

   function automatic logic [LW_P-1:0] f_clamp(input logic [LW_P-1:0] len);
      if (len == '0)
         return LW_P'(1);
      else if (32'(len) > MAX_LINE_P)
         return LW_P'(MAX_LINE_P);
      else
         return len;
   endfunction

   logic [LW_P-1:0]               r_len;
   logic [CW_P-1:0]               r_ptr;
   logic [LCW-1:0]                r_lc;
   logic                          r_valid;
   logic [NUM_TAPS_P*WIDTH_P-1:0] r_data;
   logic [NUM_TAPS_P-1:0]         r_tv;
   logic [CW_P-1:0]               r_col;
   logic                          r_eol;

   logic                          w_accept;
   logic                          w_last;
   logic [WIDTH_P-1:0]            w_rd [NL];
   logic [NUM_TAPS_P*WIDTH_P-1:0] w_taps;
   logic [NUM_TAPS_P-1:0]         w_tv;

   assign ready_o  = ~flush_i & (~r_valid | ready_i);
   assign w_accept = valid_i & ready_o;
   assign w_last   = (LW_P'(r_ptr) == (r_len - LW_P'(1)));

   // Chained line stores: line j is written with what line j-1 held at this column.
   for (genvar j = 0; j < NL; j++) begin : g_line
      logic [WIDTH_P-1:0] r_mem [MAX_LINE_P];
      logic [WIDTH_P-1:0] w_wr;
      if (j == 0) begin : g_head
         assign w_wr = data_i;
      end else begin : g_chain
         assign w_wr = w_rd[j-1];
      end
      assign w_rd[j] = r_mem[r_ptr];
      always_ff @(posedge clk_i) begin
         if (w_accept)
            r_mem[r_ptr] <= w_wr;
      end
   end

   assign w_taps[WIDTH_P-1:0] = data_i;
   assign w_tv[0]             = 1'b1;
   for (genvar k = 1; k < NUM_TAPS_P; k++) begin : g_tap
      assign w_taps[k*WIDTH_P +: WIDTH_P] = w_rd[k-1];
      assign w_tv[k]                      = (r_lc >= LCW'(k));
   end

   // Line length follows the input while held in reset; restart tracking on flush.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_len   <= f_clamp(line_len_i);
         r_ptr   <= '0;
         r_lc    <= '0;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_tv    <= '0;
         r_col   <= '0;
         r_eol   <= 1'b0;
      end else if (flush_i) begin
         r_len   <= f_clamp(line_len_i);
         r_ptr   <= '0;
         r_lc    <= '0;
         r_valid <= 1'b0;
         r_tv    <= '0;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_data  <= w_taps;
         r_tv    <= w_tv;
         r_col   <= r_ptr;
         r_eol   <= w_last;
         if (w_last) begin
            r_ptr <= '0;
            if (r_lc != LC_MAX)
               r_lc <= r_lc + LCW'(1);
         end else begin
            r_ptr <= r_ptr + CW_P'(1);
         end
      end else if (ready_i) begin
         r_valid <= 1'b0;
      end
   end

   assign valid_o     = r_valid;
   assign data_o      = r_data;
   assign tap_valid_o = r_tv;
   assign col_o       = r_col;
   assign eol_o       = r_eol;

endmodule

// File: tb/tb_linebuffer_taps.sv
// Randomised bench for linebuffer_taps against a pixel-history reference model.
module tb_linebuffer_taps;

   localparam int W  = 8;
   localparam int T  = 3;
   localparam int M  = 16;
   localparam int LW = $clog2(M + 1);
   localparam int CW = $clog2(M);

   logic            clk = 1'b0;
   logic            rst_i = 1'b1;
   logic            flush_i = 1'b0;
   logic [LW-1:0]   line_len_i = LW'(4);
   logic            valid_i = 1'b0;
   logic            ready_o;
   logic [W-1:0]    data_i = '0;
   logic            valid_o;
   logic            ready_i = 1'b1;
   logic [T*W-1:0]  data_o;
   logic [T-1:0]    tap_valid_o;
   logic [CW-1:0]   col_o;
   logic            eol_o;

   linebuffer_taps #(
      .WIDTH_P    (W),
      .NUM_TAPS_P (T),
      .MAX_LINE_P (M)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .line_len_i  (line_len_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .data_i      (data_i),
      .valid_o     (valid_o),
      .ready_i     (ready_i),
      .data_o      (data_o),
      .tap_valid_o (tap_valid_o),
      .col_o       (col_o),
      .eol_o       (eol_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [T*W-1:0] data;
      logic [T-1:0]   tv;
      logic [CW-1:0]  col;
      logic           eol;
   } exp_t;

   exp_t         q[$];
   logic [W-1:0] hist[$];
   int           len_l;
   int           n_vec = 0;
   int           n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int clampf(input int len);
      if (len == 0) return 1;
      if (len > M) return M;
      return len;
   endfunction

   // Expected tap set for the next pixel of the current session.
   function automatic exp_t model(input logic [W-1:0] d);
      exp_t e;
      int   n, line;
      n      = hist.size();
      line   = n / len_l;
      e.data = '0;
      e.data[W-1:0] = d;
      e.tv   = T'(1);
      for (int k = 1; k < T; k++) begin
         if (line >= k) begin
            e.tv[k] = 1'b1;
            e.data[k*W +: W] = hist[n - k*len_l];
         end
      end
      e.col = CW'(n % len_l);
      e.eol = ((n % len_l) == len_l - 1);
      return e;
   endfunction

   task automatic step(input bit v, input logic [W-1:0] d, input bit r, input bit fl,
                       output bit acc);
      bit             exp_rdy;
      logic [T*W-1:0] mask;
      @(negedge clk);
      valid_i = v; data_i = d; ready_i = r; flush_i = fl;
      #1;
      exp_rdy = !fl && (q.size() == 0 || r);
      chk("ready_o", 64'(ready_o), 64'(exp_rdy));
      chk("valid_o", 64'(valid_o), 64'(q.size() != 0));
      if (q.size() != 0) begin
         mask = '0;
         for (int k = 0; k < T; k++)
            if (q[0].tv[k]) mask[k*W +: W] = '1;
         chk("tap_valid_o", 64'(tap_valid_o), 64'(q[0].tv));
         chk("data_o", 64'(data_o & mask), 64'(q[0].data));
         chk("col_o", 64'(col_o), 64'(q[0].col));
         chk("eol_o", 64'(eol_o), 64'(q[0].eol));
         if (r) void'(q.pop_front());
      end
      acc = v && exp_rdy;
      if (fl) begin
         q.delete();
         hist.delete();
         len_l = clampf(int'(line_len_i));
      end else if (acc) begin
         q.push_back(model(d));
         hist.push_back(d);
      end
   endtask

   task automatic do_reset(input int len);
      @(negedge clk);
      valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
      line_len_i = LW'(len);
      rst_i = 1'b1;
      repeat (2) @(negedge clk);
      rst_i = 1'b0;
      q.delete();
      hist.delete();
      len_l = clampf(len);
      #1;
      chk("rst_valid_o", 64'(valid_o), 64'(0));
      chk("rst_data_o", 64'(data_o), 64'(0));
      chk("rst_tap_valid_o", 64'(tap_valid_o), 64'(0));
      chk("rst_col_o", 64'(col_o), 64'(0));
      chk("rst_eol_o", 64'(eol_o), 64'(0));
   endtask

   task automatic drain();
      bit a;
      repeat (3) step(1'b0, '0, 1'b1, 1'b0, a);
   endtask

   task automatic flush_to(input int len);
      bit a;
      line_len_i = LW'(len);
      step(1'b0, '0, 1'b1, 1'b1, a);
   endtask

   initial begin
      bit a;
      int accepted, cycles;

      // Basic fill with a 3-cycle stall mid-stream
      do_reset(4);
      for (int p = 0; p < 16; p++) begin
         step(1'b1, W'(p), 1'b1, 1'b0, a);
         if (p == 6)
            repeat (3) step(1'b1, W'(p + 1), 1'b0, 1'b0, a);
      end
      drain();

      // Flush and resize to 6
      do_reset(4);
      for (int p = 0; p < 10; p++) step(1'b1, W'(p + 100), 1'b1, 1'b0, a);
      flush_to(6);
      for (int p = 0; p < 14; p++) step(1'b1, W'($urandom), 1'b1, 1'b0, a);
      drain();

      // Random bubbles on both sides at L=5
      flush_to(5);
      accepted = 0;
      cycles   = 0;
      while (accepted < 200 && cycles < 4000) begin
         step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)), 1'b0, a);
         if (a) accepted++;
         cycles++;
      end
      chk("bubble_accepts", 64'(accepted), 64'(200));
      drain();

      // Clamp low and high
      flush_to(0);
      for (int p = 0; p < 8; p++) step(1'b1, W'($urandom), 1'b1, 1'b0, a);
      drain();
      flush_to(20);
      for (int p = 0; p < 40; p++) step(1'b1, W'($urandom), 1'($urandom_range(0, 1)), 1'b0, a);
      drain();

      // Asynchronous reset while an output is pending
      flush_to(4);
      for (int p = 0; p < 5; p++) step(1'b1, W'(p + 1), 1'b1, 1'b0, a);
      step(1'b0, '0, 1'b0, 1'b0, a);
      chk("pre_rst_valid_o", 64'(valid_o), 64'(1));
      #1;
      valid_i = 1'b0;
      rst_i   = 1'b1;
      #1;
      chk("async_valid_o", 64'(valid_o), 64'(0));
      chk("async_tap_valid_o", 64'(tap_valid_o), 64'(0));
      chk("async_data_o", 64'(data_o), 64'(0));
      @(negedge clk);
      rst_i = 1'b0;
      q.delete();
      hist.delete();
      len_l = clampf(int'(line_len_i));
      for (int p = 0; p < 10; p++) step(1'b1, W'($urandom), 1'b1, 1'b0, a);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
